// File: rtl/decimal_digit_ndig.sv
// Registered binary-to-decimal digit extractor with an active-low 7-segment decoder.
//
// Picks the decimal digit at weight 10**POSITION out of an unsigned binary number.
// It registers the segment pattern for that digit and registers the number with that
// digit's contribution removed. Instances chain from the most significant digit down:
// reduced_number of the POSITION=k stage feeds number of the POSITION=k-1 stage.
// Each stage adds one cycle of latency.
//
// Parameters:
//   WIDTH    - bit width of number / reduced_number (4..16)
//   POSITION - decimal digit index, 0 = units (0..4); 10**POSITION must fit in WIDTH bits
//
// Ports:
//   clock          - system clock, rising edge
//   n_reset        - asynchronous active-low reset; outputs blank / zero while low
//   number         - unsigned binary value to decode
//   data[6:0]      - active-low segments, data[0]=a ... data[6]=g
//   reduced_number - number - digit * 10**POSITION, registered
//
// Build option:
//   DECIMAL_DIGIT_LEADING_BLANK_EN - when defined, a non-units stage blanks its display
//   whenever this digit and every higher digit are zero (number < 10**POSITION).

module decimal_digit_ndig #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned POSITION = 1
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] number,
    output logic [6:0]       data,
    output logic [WIDTH-1:0] reduced_number
);

    // Digit weight. It is an elaboration-time constant, so the divide below reduces to
    // constant logic.
    localparam int unsigned W = 10 ** POSITION;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

`ifdef DECIMAL_DIGIT_LEADING_BLANK_EN
    localparam bit LEADING_BLANK = 1'b1;
`else
    localparam bit LEADING_BLANK = 1'b0;
`endif

    // Parameter legality.
    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("decimal_digit_ndig: WIDTH must be in 4..16");
    end
    if (POSITION > 4) begin : g_bad_position
        $error("decimal_digit_ndig: POSITION must be in 0..4");
    end
    if (W > (2 ** WIDTH) - 1) begin : g_bad_weight
        $error("decimal_digit_ndig: 10**POSITION does not fit in WIDTH bits");
    end

    // The legality checks guarantee that both constants fit in WIDTH bits.
    localparam logic [WIDTH-1:0] WEIGHT = WIDTH'(W);
    localparam logic [WIDTH-1:0] TEN    = WIDTH'(10);

    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] reduced_d;
    logic [6:0]       data_d;
    logic             blank;

    logic [6:0]       data_q;
    logic [WIDTH-1:0] reduced_q;

    // Arithmetic. digit*WEIGHT <= number, so the WIDTH-bit product and difference never
    // wrap. Higher digits stay inside reduced_number on purpose.
    always_comb begin
        quotient  = number / WEIGHT;
        digit     = quotient % TEN;
        reduced_d = number - (digit * WEIGHT);
    end

    // Segment decode, active low (g f e d c b a).
    always_comb begin
        data_d = SEG_BLANK;
        case (digit)
            WIDTH'(0): data_d = 7'b1000000;
            WIDTH'(1): data_d = 7'b1111001;
            WIDTH'(2): data_d = 7'b0100100;
            WIDTH'(3): data_d = 7'b0110000;
            WIDTH'(4): data_d = 7'b0011001;
            WIDTH'(5): data_d = 7'b0010010;
            WIDTH'(6): data_d = 7'b0000010;
            WIDTH'(7): data_d = 7'b1111000;
            WIDTH'(8): data_d = 7'b0000000;
            WIDTH'(9): data_d = 7'b0010000;
            default:   data_d = SEG_BLANK;
        endcase
    end

    // number < weight means this digit and all higher ones are zero. The units stage
    // never blanks.
    always_comb begin
        blank = 1'b0;
        if (LEADING_BLANK && (POSITION > 0) && (number < WEIGHT)) begin
            blank = 1'b1;
        end
    end

    // Single register stage. The registers reload every cycle, so an X on number only
    // affects the cycle that captured it.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            data_q    <= SEG_BLANK;
            reduced_q <= '0;
        end else begin
            data_q    <= blank ? SEG_BLANK : data_d;
            reduced_q <= reduced_d;
        end
    end

    assign data           = data_q;
    assign reduced_number = reduced_q;

endmodule

// File: tb/tb_decimal_digit_ndig.sv
// Self-checking bench for decimal_digit_ndig.
// It instantiates three stages:
//   dut     - a tens stage (WIDTH=6, POSITION=1)
//   u_chain - a units stage fed by the tens stage's reduced_number
//   u_units - a standalone units stage with its own input

module tb_decimal_digit_ndig;

    typedef struct packed {
        logic [6:0] data;
        logic [5:0] red;
    } exp_t;

    typedef struct packed {
        logic [5:0] num;
        logic [6:0] data;
        logic [5:0] red;
    } vec_t;

`ifdef DECIMAL_DIGIT_LEADING_BLANK_EN
    localparam logic [6:0] ZERO_LEAD = 7'b1111111;
    localparam bit         BLANK_EN  = 1'b1;
`else
    localparam logic [6:0] ZERO_LEAD = 7'b1000000;
    localparam bit         BLANK_EN  = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       n_reset;
    logic [5:0] dut_num;
    logic [5:0] units_num;
    logic [6:0] dut_data;
    logic [5:0] dut_red;
    logic [6:0] chain_data;
    logic [5:0] chain_red;
    logic [6:0] units_data;
    logic [5:0] units_red;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    vec_t tab[9];
    logic [6:0] seg_tab[10];

    always #5 clock = ~clock;

    decimal_digit_ndig #(.WIDTH(6), .POSITION(1)) dut (
        .clock          (clock),
        .n_reset        (n_reset),
        .number         (dut_num),
        .data           (dut_data),
        .reduced_number (dut_red)
    );

    decimal_digit_ndig #(.WIDTH(6), .POSITION(0)) u_chain (
        .clock          (clock),
        .n_reset        (n_reset),
        .number         (dut_red),
        .data           (chain_data),
        .reduced_number (chain_red)
    );

    decimal_digit_ndig #(.WIDTH(6), .POSITION(0)) u_units (
        .clock          (clock),
        .n_reset        (n_reset),
        .number         (units_num),
        .data           (units_data),
        .reduced_number (units_red)
    );

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual data=%b red=%0d expected data=%b red=%0d",
                     name, act[12:6], act[5:0], exp[12:6], exp[5:0]);
        end
    endtask

    function automatic exp_t tens_model(input int n);
        exp_t e;
        int   d;
        d     = (n / 10) % 10;
        e.data = (BLANK_EN && n < 10) ? 7'b1111111 : seg_tab[d];
        e.red  = 6'(n - d * 10);
        return e;
    endfunction

    task automatic drive(input int n);
        dut_num = 6'(n);
        sb.push_back(tens_model(n));
    endtask

    task automatic sample(input string name);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual data=%b red=%0d", name, dut_data, dut_red);
        end else begin
            e = sb.pop_front();
            check(name, {dut_data, dut_red}, {e.data, e.red});
        end
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        tab[0] = '{6'd0,  ZERO_LEAD,  6'd0};
        tab[1] = '{6'd7,  ZERO_LEAD,  6'd7};
        tab[2] = '{6'd9,  ZERO_LEAD,  6'd9};
        tab[3] = '{6'd10, 7'b1111001, 6'd0};
        tab[4] = '{6'd19, 7'b1111001, 6'd9};
        tab[5] = '{6'd37, 7'b0110000, 6'd7};
        tab[6] = '{6'd42, 7'b0011001, 6'd2};
        tab[7] = '{6'd59, 7'b0010010, 6'd9};
        tab[8] = '{6'd63, 7'b0000010, 6'd3};

        // Reset: held low with a live input, outputs must stay blank / zero.
        n_reset   = 1'b0;
        dut_num   = 6'd37;
        units_num = 6'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_hold", {dut_data, dut_red}, {7'b1111111, 6'd0});
        check("reset_hold_units", {units_data, units_red}, {7'b1111111, 6'd0});

        // Release between edges; the first edge captures 37.
        @(negedge clock);
        n_reset = 1'b1;
        drive(37);
        sample("reset_release");

        // Table of spot values.
        for (int i = 0; i < 9; i++) begin
            dut_num = tab[i].num;
            @(posedge clock);
            #1;
            check($sformatf("table_%0d", tab[i].num), {dut_data, dut_red},
                  {tab[i].data, tab[i].red});
        end

        // Full sweep through the scoreboard. The chained units stage lags by one cycle.
        for (int n = 0; n < 64; n++) begin
            drive(n);
            sample($sformatf("sweep_%0d", n));
            if (n > 0) begin
                check($sformatf("chain_%0d", n - 1), {chain_data, chain_red},
                      {seg_tab[(n - 1) % 10], 6'd0});
            end
        end

        // Standalone units stage.
        units_num = 6'd47;
        @(posedge clock);
        #1;
        check("units_47", {units_data, units_red}, {7'b1111000, 6'd40});
        units_num = 6'd63;
        @(posedge clock);
        #1;
        check("units_63", {units_data, units_red}, {7'b0110000, 6'd60});
        units_num = 6'd0;
        @(posedge clock);
        #1;
        check("units_0", {units_data, units_red}, {7'b1000000, 6'd0});

        // Two-stage chain: 42 shows 4 at the tens stage, then 2 at the units stage.
        drive(42);
        sample("chain42_tens");
        drive(0);
        sample("chain42_tens_next");
        check("chain42_units", {chain_data, chain_red}, {7'b0100100, 6'd0});

        // An X input must not disturb the result of the next valid input.
        dut_num = 'x;
        @(posedge clock);
        #1;
        drive(25);
        sample("after_x");

        // Asynchronous reset mid-stream, asserted between edges.
        drive(55);
        sample("pre_async_reset");
        #2;
        n_reset = 1'b0;
        #1;
        check("async_reset_now", {dut_data, dut_red}, {7'b1111111, 6'd0});
        @(posedge clock);
        #1;
        check("async_reset_held", {dut_data, dut_red}, {7'b1111111, 6'd0});
        @(negedge clock);
        n_reset = 1'b1;
        drive(58);
        sample("post_async_reset");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain leftover=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
